fetch_pc_unit: RTL

//  Fetch-stage PC generator. It sits directly upstream of the BTB.
//  - Holds the fetch PC and drives the BTB lookup address.
//  - Picks next PC: redirect > BTB-predicted target > PC+2.
//  - Keeps an in-order queue of {pc, predicted_next} for every fetched instruction.
//  - At retirement, compares each entry against the resolved next PC; a mismatch

---
 rtl/fetch_pc_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC generator with BTB steering and a retire-time
// prediction queue that raises flush/redirect on a mispredicted next PC.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   stall                        hazard stall, blocks fetch fire
//   btb_hit, btb_target          BTB lookup result for pc_if
//   retire_valid/pc/next_pc      retiring instruction and its true next PC
//   pc_if, fetch_valid           fetch PC (BTB address) and fetch permission
//   pred_next_if                 predicted next PC for pc_if
//   flush, redirect_pc           mispredict kill and correct PC
//   pq_full, seq_err             queue full, sticky protocol error
//   mispredict_cnt               saturating mispredict counter
module fetch_pc_unit #(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        btb_hit,
  input  logic [15:0] btb_target,
  input  logic        retire_valid,
  input  logic [15:0] retire_pc,
  input  logic [15:0] retire_next_pc,
  output logic [15:0] pc_if,
  output logic        fetch_valid,
  output logic [15:0] pred_next_if,
  output logic        flush,
  output logic [15:0] redirect_pc,
  output logic        pq_full,
  output logic        seq_err,
  output logic [15:0] mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   q_pc [DEPTH];
  logic [15:0]   q_pn [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic empty;
  logic live;
  logic pc_bad;
  logic mis;
  logic pop;
  logic err_ev;
  logic fire;

  assign empty   = (count == '0);
  assign pq_full = (count == (AW+1)'(DEPTH));

  assign pred_next_if = btb_hit ? btb_target
                                : pc_if + 16'd2;

  // A retire whose PC disagrees with the head is a
  // protocol error, not a mispredict: pop, no flush.
  always_comb begin
    live   = retire_valid & ~empty;
    pc_bad = live & (retire_pc != q_pc[head]);
    mis    = live & ~pc_bad
           & (q_pn[head] != retire_next_pc);
    pop    = live & ~mis;
    err_ev = (retire_valid & empty) | pc_bad;
  end

  assign flush       = mis;
  assign redirect_pc = mis ? retire_next_pc : 16'h0000;
  assign fetch_valid = ~pq_full & ~flush;
  assign fire        = fetch_valid & ~stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_if          <= RESET_PC;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      seq_err        <= 1'b0;
      mispredict_cnt <= 16'h0000;
    end else begin
      seq_err <= seq_err | err_ev;
      if (flush) begin
        pc_if <= retire_next_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        if (mispredict_cnt != 16'hFFFF)
          mispredict_cnt <= mispredict_cnt + 16'd1;
      end else begin
        if (fire) begin
          pc_if <= pred_next_if;
          tail  <= tail + AW'(1);
        end
        if (pop)
          head <= head + AW'(1);
        count <= count + (AW+1)'(fire)
                       - (AW+1)'(pop);
      end
    end
  end

  // Payload needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (fire) begin
      q_pc[tail] <= pc_if;
      q_pn[tail] <= pred_next_if;
    end
  end

endmodule
